// File: rtl/mem_stall_ctrl_pkg.sv
// Shared CPU package: memory-stage stall FSM states and defaults.
// Holds the 2-bit state encoding, default ack timeout and helpers.
package mem_stall_ctrl_pkg;

  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SYS  = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  function automatic logic is_aligned(
    input logic [31:0] a
  );
    return a[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_stall_ctrl.sv
// Memory-stage stall controller: sequences data-memory and syscall
// handshakes and stalls F/D/E, holds M and bubbles W while waiting.
module mem_stall_ctrl
  import mem_stall_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memtoreg_m,
  input  logic        memwrite_m,
  input  logic        syscall_m,
  input  logic [31:0] aluout_m,
  input  logic [31:0] writedata_m,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  input  logic        sys_done,
  output logic        sys_busy,
  output logic        stall_fde,
  output logic        en_m,
  output logic        flush_w,
  output logic [31:0] readdata_m,
  output logic        addr_err,
  output logic        timeout_err
);

  localparam int unsigned CW =
    (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW:0] TO_V = TIMEOUT[CW:0];
  localparam logic [CW:0] ONE  = (CW+1)'(1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   cnt_inc;
  logic [31:0]   readdata_q;
  logic          addr_err_q;

  logic mem_op, aligned;
  logic req_c, stall_c, mis_c;

  assign mem_op  = memtoreg_m | memwrite_m;
  assign aligned = is_aligned(aluout_m);
  assign cnt_inc = {1'b0, cnt_q} + ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_c   = 1'b0;
    stall_c = 1'b0;
    mis_c   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (syscall_m) begin
          state_d = ST_SYS;
          stall_c = 1'b1;
        end else if (mem_op && aligned) begin
          req_c = 1'b1;
          if (!dmem_ack) begin
            state_d = ST_REQ;
            cnt_d   = '0;
            stall_c = 1'b1;
          end
        end else if (mem_op) begin
          mis_c = 1'b1;
        end
      end
      ST_REQ: begin
        req_c = 1'b1;
        if (dmem_ack) begin
          state_d = ST_IDLE;
        end else begin
          stall_c = 1'b1;
          // saturate at TIMEOUT; reaching it is fatal
          if (cnt_inc >= TO_V) begin
            cnt_d   = TO_V[CW-1:0];
            state_d = ST_ERR;
          end else begin
            cnt_d = cnt_inc[CW-1:0];
          end
        end
      end
      ST_SYS: begin
        if (sys_done) state_d = ST_IDLE;
        else          stall_c = 1'b1;
      end
      ST_ERR: begin
        stall_c = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      readdata_q <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_err_q <= mis_c;
      // acks outside a live request are stray
      if (dmem_ack && memtoreg_m && req_c)
        readdata_q <= dmem_rdata;
    end
  end

  // reset aborts an in-flight request at once
  assign dmem_req    = rst_n & req_c;
  assign dmem_we     = memwrite_m;
  assign dmem_addr   = aluout_m;
  assign dmem_wdata  = writedata_m;
  assign sys_busy    = (state_q == ST_SYS);
  assign stall_fde   = rst_n & stall_c;
  assign en_m        = ~(rst_n & stall_c);
  assign flush_w     = rst_n & stall_c;
  assign readdata_m  = readdata_q;
  assign addr_err    = addr_err_q;
  assign timeout_err = (state_q == ST_ERR);

endmodule

// File: doc/mem_stall_ctrl.md
MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 255, meaning max cycles a data-memory request may wait for ack before error.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have inputs memtoreg_m (1, load in M), memwrite_m (1, store in M), syscall_m (1, syscall in M), aluout_m (32, byte address) and writedata_m (32, store data).
REQ-005 The block SHALL have outputs dmem_req (1), dmem_we (1), dmem_addr (32) and dmem_wdata (32) to data memory, and input dmem_ack (1) and dmem_rdata (32) from it.
REQ-006 The block SHALL have input sys_done (1) from the syscall handler and output sys_busy (1) to it.
REQ-007 The block SHALL have outputs stall_fde (1, hold F/D/E pipeline registers), en_m (1, M register load enable) and flush_w (1, bubble into W register).
REQ-008 The block SHALL have outputs readdata_m (32, captured load data), addr_err (1, one-cycle misalignment pulse) and timeout_err (1, sticky).

Function
REQ-009 The FSM SHALL have states IDLE, REQ, SYS and ERR; mem_op = memtoreg_m | memwrite_m; aligned = aluout_m[1:0]==0.
REQ-010 In IDLE with syscall_m=1, the FSM SHALL go to SYS; syscall has priority over mem_op.
REQ-011 In IDLE with mem_op, aligned and dmem_ack=0, the FSM SHALL go to REQ; with dmem_ack=1 in the same cycle, it SHALL stay in IDLE (zero-wait access).
REQ-012 In IDLE with mem_op and not aligned, the FSM SHALL raise addr_err for one cycle, issue no request and not stall.
REQ-013 dmem_req SHALL be asserted combinationally in IDLE with mem_op, aligned and no syscall, and SHALL be held high throughout REQ.
REQ-014 dmem_addr and dmem_wdata SHALL equal aluout_m and writedata_m, with dmem_we = memwrite_m; these values are stable while stalled because the M register is held.
REQ-015 In REQ, dmem_ack=1 SHALL return the FSM to IDLE; dmem_req SHALL deassert in the following cycle.
REQ-016 In REQ, a wait counter SHALL count cycles with dmem_ack=0; when the count reaches TIMEOUT, the FSM SHALL go to ERR and dmem_req SHALL drop.
REQ-017 The counter SHALL clear on entry to REQ, be wide enough for TIMEOUT without wrap-around, and saturate.
REQ-018 In SYS, sys_busy SHALL be 1; sys_done=1 SHALL return the FSM to IDLE.
REQ-019 ERR SHALL be terminal until reset; timeout_err SHALL be 1 in ERR and the pipeline SHALL remain stalled.
REQ-020 stall SHALL be 1 for: (IDLE & syscall_m); (IDLE & mem_op & aligned & ~dmem_ack); (REQ & ~dmem_ack); (SYS & ~sys_done); and ERR.
REQ-021 The stall outputs SHALL be driven as stall_fde = stall, en_m = ~stall, flush_w = stall.
REQ-022 On every cycle with dmem_ack=1 and memtoreg_m=1, readdata_m SHALL register dmem_rdata; otherwise readdata_m SHALL hold its value.
REQ-023 A dmem_ack received outside an active request (stray ack) SHALL be ignored.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, counter 0, readdata_m 0, timeout_err 0 and addr_err 0.
REQ-025 Asserting rst_n=0 mid-request SHALL drop dmem_req in the same cycle; memory shall treat this as an abort.
REQ-026 After reset, outputs SHALL be dmem_req=0, sys_busy=0, stall_fde=0, en_m=1 and flush_w=0.

Structure
REQ-027 The state encoding (2 bits) and the TIMEOUT default SHALL live in the shared CPU package; no sub-module is required.
REQ-028 Next-state/stall logic SHALL be combinational; state, counter, readdata_m and addr_err SHALL be registers.

Verification
REQ-029 The bench SHALL check a zero-wait load: memtoreg_m=1, aluout_m=0x100, ack in the same cycle, rdata=0xDEADBEEF -> no stall, and readdata_m=0xDEADBEEF on the next cycle.
REQ-030 The bench SHALL check a 3-wait store: memwrite_m=1, addr 0x204, ack on the 4th cycle -> stall_fde=1 for 3 cycles, dmem_req high for 4 cycles with stable addr/wdata, then en_m=1.
REQ-031 The bench SHALL check a misaligned load at addr 0x103 -> addr_err high for 1 cycle, dmem_req=0 and stall=0.
REQ-032 The bench SHALL check a syscall with sys_done asserted after 5 cycles -> sys_busy high and stall high for 5 cycles, released in the sys_done cycle.
REQ-033 The bench SHALL check a timeout with TIMEOUT=4 and no ack -> ERR after 4 REQ cycles, timeout_err=1 and stall stuck at 1 until rst_n=0.
REQ-034 The bench SHALL check reset asserted mid-REQ -> dmem_req=0 immediately, and a clean zero-wait access succeeds after release.
